// File: rtl/clock_mode_controller.sv
// Timebase sequencer for the digital clock: 1 Hz tick prescaler, RUN/PAUSE/SET mode FSM,
// increment strobes with hold-to-repeat, and the 2 Hz blink enable for the field being set.
module clock_mode_controller #(
    parameter int DIV_VALUE    = 50000000,
    parameter int BLINK_DIV    = 12500000,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_DIV   = 12500000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_pause,
    input  logic       btn_inc,
    output logic       sec_tick,
    output logic       inc_hour,
    output logic       inc_min,
    output logic       inc_sec,
    output logic [2:0] mode,
    output logic       blink,
    output logic       running
);

    localparam int CNT_W  = $clog2(DIV_VALUE);
    localparam int BLK_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int HOLD_W = $clog2(REPEAT_DELAY + 1);
    localparam int REP_W  = (REPEAT_DIV > 1) ? $clog2(REPEAT_DIV) : 1;

    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DIV_VALUE - 1);
    localparam logic [BLK_W-1:0]  BLK_MAX  = BLK_W'(BLINK_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(REPEAT_DELAY);
    localparam logic [REP_W-1:0]  REP_MAX  = REP_W'(REPEAT_DIV - 1);

    typedef enum logic [2:0] {
        S_RUN      = 3'd0,
        S_PAUSE    = 3'd1,
        S_SET_HOUR = 3'd2,
        S_SET_MIN  = 3'd3,
        S_SET_SEC  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic               hist_mode_q, hist_pause_q, hist_inc_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               tick_q, tick_d;
    logic [BLK_W-1:0]   blk_cnt_q, blk_cnt_d;
    logic               blink_q, blink_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [REP_W-1:0]   rep_q, rep_d;
    logic               inc_hour_q, inc_hour_d;
    logic               inc_min_q, inc_min_d;
    logic               inc_sec_q, inc_sec_d;
    logic               running_q, running_d;

    logic press_mode, press_pause, press_inc;
    logic mode_change, in_run, in_set, set_next;
    logic rep_fire, inc_fire;

    assign press_mode  = btn_mode  & ~hist_mode_q;
    assign press_pause = btn_pause & ~hist_pause_q;
    assign press_inc   = btn_inc   & ~hist_inc_q;

    // Mode press outranks a simultaneous pause press; pause only toggles RUN/PAUSE.
    always_comb begin
        state_d = state_q;
        if (press_mode) begin
            case (state_q)
                S_RUN, S_PAUSE: state_d = S_SET_HOUR;
                S_SET_HOUR:     state_d = S_SET_MIN;
                S_SET_MIN:      state_d = S_SET_SEC;
                default:        state_d = S_RUN;
            endcase
        end else if (press_pause) begin
            case (state_q)
                S_RUN:   state_d = S_PAUSE;
                S_PAUSE: state_d = S_RUN;
                S_SET_HOUR, S_SET_MIN, S_SET_SEC: state_d = state_q;
                default: state_d = S_RUN;
            endcase
        end else begin
            case (state_q)
                S_RUN, S_PAUSE, S_SET_HOUR, S_SET_MIN, S_SET_SEC: state_d = state_q;
                default: state_d = S_RUN;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign mode_change = (state_d != state_q);
    assign in_run      = (state_q == S_RUN);
    assign in_set      = (state_q == S_SET_HOUR) || (state_q == S_SET_MIN) || (state_q == S_SET_SEC);
    assign set_next    = (state_d == S_SET_HOUR) || (state_d == S_SET_MIN) || (state_d == S_SET_SEC);

    // A wrap in the cycle RUN is left still resets the count but drops the tick.
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if ((state_d == S_SET_HOUR && state_q != S_SET_HOUR) ||
            (state_q == S_SET_SEC && state_d == S_RUN)) begin
            cnt_d = '0;
        end else if (in_run) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d  = '0;
                tick_d = (state_d == S_RUN);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        blk_cnt_d = blk_cnt_q;
        blink_d   = blink_q;
        if (!set_next || mode_change) begin
            blk_cnt_d = '0;
            blink_d   = 1'b1;
        end else if (blk_cnt_q == BLK_MAX) begin
            blk_cnt_d = '0;
            blink_d   = ~blink_q;
        end else begin
            blk_cnt_d = blk_cnt_q + BLK_W'(1);
        end
    end

    // hold_q counts cycles since the press (saturating at the delay); rep_q then paces repeats.
    always_comb begin
        hold_d   = hold_q;
        rep_d    = rep_q;
        rep_fire = 1'b0;
        if (!in_set || mode_change || !btn_inc) begin
            hold_d = '0;
            rep_d  = '0;
        end else if (press_inc) begin
            hold_d = HOLD_W'(1);
            rep_d  = '0;
        end else if (hold_q == HOLD_MAX) begin
            rep_fire = (rep_q == '0);
            rep_d    = (rep_q == REP_MAX) ? '0 : rep_q + REP_W'(1);
        end else if (hold_q != '0) begin
            hold_d = hold_q + HOLD_W'(1);
        end
    end

    always_comb begin
        inc_fire   = in_set && !mode_change && (press_inc || rep_fire);
        inc_hour_d = inc_fire && (state_q == S_SET_HOUR);
        inc_min_d  = inc_fire && (state_q == S_SET_MIN);
        inc_sec_d  = inc_fire && (state_q == S_SET_SEC);
        running_d  = (state_d == S_RUN);
    end

    // History regs reset to 1 so a key held through reset needs a release before it counts.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            hist_mode_q  <= 1'b1;
            hist_pause_q <= 1'b1;
            hist_inc_q   <= 1'b1;
            cnt_q        <= '0;
            tick_q       <= 1'b0;
            blk_cnt_q    <= '0;
            blink_q      <= 1'b1;
            hold_q       <= '0;
            rep_q        <= '0;
            inc_hour_q   <= 1'b0;
            inc_min_q    <= 1'b0;
            inc_sec_q    <= 1'b0;
            running_q    <= 1'b1;
        end else begin
            hist_mode_q  <= btn_mode;
            hist_pause_q <= btn_pause;
            hist_inc_q   <= btn_inc;
            cnt_q        <= cnt_d;
            tick_q       <= tick_d;
            blk_cnt_q    <= blk_cnt_d;
            blink_q      <= blink_d;
            hold_q       <= hold_d;
            rep_q        <= rep_d;
            inc_hour_q   <= inc_hour_d;
            inc_min_q    <= inc_min_d;
            inc_sec_q    <= inc_sec_d;
            running_q    <= running_d;
        end
    end

    assign sec_tick = tick_q;
    assign inc_hour = inc_hour_q;
    assign inc_min  = inc_min_q;
    assign inc_sec  = inc_sec_q;
    assign mode     = state_q;
    assign blink    = blink_q;
    assign running  = running_q;

endmodule

// File: tb/tb_clock_mode_controller.sv
// Directed bench for clock_mode_controller with small divider values; cycle numbers
// below count from the first cycle after the initial reset is released.
module tb_clock_mode_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_mode, btn_pause, btn_inc;
    logic       sec_tick, inc_hour, inc_min, inc_sec;
    logic [2:0] mode;
    logic       blink, running;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    clock_mode_controller #(
        .DIV_VALUE   (10),
        .BLINK_DIV   (4),
        .REPEAT_DELAY(20),
        .REPEAT_DIV  (5)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .btn_mode (btn_mode),
        .btn_pause(btn_pause),
        .btn_inc  (btn_inc),
        .sec_tick (sec_tick),
        .inc_hour (inc_hour),
        .inc_min  (inc_min),
        .inc_sec  (inc_sec),
        .mode     (mode),
        .blink    (blink),
        .running  (running)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compared vector: {sec_tick, inc_hour, inc_min, inc_sec, mode[2:0], blink, running}
    task automatic chk(input string tag, input int cyc, input logic st, input logic ih,
                       input logic im, input logic is, input logic [2:0] md,
                       input logic bl, input logic rn);
        logic [8:0] obs;
        logic [8:0] exp;
        obs = {sec_tick, inc_hour, inc_min, inc_sec, mode, blink, running};
        exp = {st, ih, im, is, md, bl, rn};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; btn_mode = 1'b0; btn_pause = 1'b0; btn_inc = 1'b0;
        repeat (3) tick();
        chk("reset_state", -1, 0, 0, 0, 0, 3'd0, 1, 1);
        reset = 1'b0;

        for (int c = 1; c <= 33; c++) begin
            tick();
            chk("run_ticks", c, (c % 10 == 0), 0, 0, 0, 3'd0, 1, 1);
        end

        btn_pause = 1'b1;
        tick();
        chk("pause_enter", 34, 0, 0, 0, 0, 3'd1, 1, 0);
        btn_pause = 1'b0;
        for (int c = 35; c <= 50; c++) begin
            tick();
            chk("paused_no_tick", c, 0, 0, 0, 0, 3'd1, 1, 0);
        end

        btn_pause = 1'b1;
        tick();
        chk("resume", 51, 0, 0, 0, 0, 3'd0, 1, 1);
        btn_pause = 1'b0;
        for (int c = 52; c <= 57; c++) begin
            tick();
            chk("resume_count", c, (c == 57), 0, 0, 0, 3'd0, 1, 1);
        end

        btn_mode = 1'b1;
        tick();
        btn_mode = 1'b0;
        for (int c = 58; c <= 104; c++) begin
            btn_inc = (c >= 60 && c <= 99);
            chk("set_hour_repeat", c, 0,
                (c == 61 || c == 81 || c == 86 || c == 91 || c == 96), 0, 0,
                3'd2, (((c - 58) / 4) % 2 == 0), 0);
            tick();
        end

        btn_mode = 1'b1;
        tick();
        for (int c = 106; c <= 117; c++) begin
            btn_mode = 1'b0;
            btn_inc  = (c == 108);
            chk("set_min_blink_inc", c, 0, 0, (c == 109), 0, 3'd3,
                (((c - 106) / 4) % 2 == 0), 0);
            tick();
        end

        btn_mode = 1'b1;
        tick();
        chk("set_sec_enter", 119, 0, 0, 0, 0, 3'd4, 1, 0);
        btn_mode = 1'b0;
        tick();
        chk("set_sec_hold", 120, 0, 0, 0, 0, 3'd4, 1, 0);
        btn_mode = 1'b1;
        tick();
        btn_mode = 1'b0;
        for (int c = 121; c <= 131; c++) begin
            btn_inc = (c == 123);
            chk("back_to_run", c, (c == 131), 0, 0, 0, 3'd0, 1, 1);
            tick();
        end
        btn_inc = 1'b0;

        btn_mode = 1'b1; btn_pause = 1'b1;
        tick();
        chk("mode_beats_pause", 133, 0, 0, 0, 0, 3'd2, 1, 0);
        btn_mode = 1'b0; btn_pause = 1'b0;
        tick();
        chk("set_hour_idle", 134, 0, 0, 0, 0, 3'd2, 1, 0);
        btn_mode = 1'b1; btn_inc = 1'b1;
        tick();
        chk("mode_beats_inc", 135, 0, 0, 0, 0, 3'd3, 1, 0);
        btn_mode = 1'b0;
        tick();
        chk("inc_held_no_press", 136, 0, 0, 0, 0, 3'd3, 1, 0);
        tick();
        chk("inc_held_no_press", 137, 0, 0, 0, 0, 3'd3, 1, 0);
        btn_mode = 1'b1;
        tick();
        chk("set_sec_inc_held", 138, 0, 0, 0, 0, 3'd4, 1, 0);

        reset = 1'b1; btn_pause = 1'b1;
        tick();
        chk("mid_reset", 139, 0, 0, 0, 0, 3'd0, 1, 1);
        tick();
        chk("mid_reset_hold", 140, 0, 0, 0, 0, 3'd0, 1, 1);
        reset = 1'b0; btn_mode = 1'b0; btn_pause = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk("post_reset_tick", 140 + k, (k == 10), 0, 0, 0, 3'd0, 1, 1);
        end

        btn_mode = 1'b1;
        tick();
        chk("held_inc_after_reset", 151, 0, 0, 0, 0, 3'd2, 1, 0);
        btn_mode = 1'b0;
        tick();
        chk("held_inc_after_reset", 152, 0, 0, 0, 0, 3'd2, 1, 0);
        tick();
        chk("held_inc_after_reset", 153, 0, 0, 0, 0, 3'd2, 1, 0);
        btn_inc = 1'b0;
        tick();
        chk("inc_released", 154, 0, 0, 0, 0, 3'd2, 1, 0);
        btn_inc = 1'b1;
        tick();
        chk("inc_repressed", 155, 0, 1, 0, 0, 3'd2, 0, 0);
        btn_inc = 1'b0;
        tick();
        chk("inc_single", 156, 0, 0, 0, 0, 3'd2, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
